// File: rtl/clause_array_state_lists.sv
// Register bank for one bin: the clause literal matrix, the variable-state list and the
// level-state list. Each is stored as separate fields and packed into the SAT engine bus formats.
module clause_array_state_lists #(
  parameter int unsigned NUM_CLAUSES      = 8,
  parameter int unsigned NUM_VARS         = 8,
  parameter int unsigned NUM_LVLS         = 8,
  parameter int unsigned WIDTH_LVL        = 16,
  parameter int unsigned WIDTH_BIN_ID     = 10,
  parameter int unsigned WIDTH_VAR_STATES = 2 + 1 + WIDTH_LVL,
  parameter int unsigned WIDTH_LVL_STATES = WIDTH_BIN_ID + 1,
  parameter int unsigned CIDX_W = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1,
  parameter int unsigned VIDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
  parameter int unsigned LIDX_W = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear_i,
  // clause literal matrix
  input  logic                                 lit_we_i,
  input  logic [CIDX_W-1:0]                    lit_cidx_i,
  input  logic [VIDX_W-1:0]                    lit_vidx_i,
  input  logic [1:0]                           lit_code_i,
  input  logic [CIDX_W-1:0]                    c_rd_idx_i,
  output logic [2*NUM_VARS-1:0]                clause_o,
  // variable states
  input  logic                                 vs_we_i,
  input  logic [VIDX_W-1:0]                    vs_idx_i,
  input  logic [1:0]                           vs_value_i,
  input  logic                                 vs_implied_i,
  input  logic [WIDTH_LVL-1:0]                 vs_level_i,
  input  logic                                 vs_load_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
  input  logic [VIDX_W-1:0]                    vs_rd_idx_i,
  output logic [1:0]                           vs_value_o,
  output logic                                 vs_implied_o,
  output logic [WIDTH_LVL-1:0]                 vs_level_o,
  // level states
  input  logic                                 ls_we_i,
  input  logic [LIDX_W-1:0]                    ls_idx_i,
  input  logic [WIDTH_BIN_ID-1:0]              ls_dcd_bin_i,
  input  logic                                 ls_has_bkt_i,
  input  logic                                 ls_load_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
  input  logic [LIDX_W-1:0]                    ls_rd_idx_i,
  output logic [WIDTH_BIN_ID-1:0]              ls_dcd_bin_o,
  output logic                                 ls_has_bkt_o
);

  logic [1:0]              lit_q      [NUM_CLAUSES][NUM_VARS];
  logic [1:0]              vs_value_q [NUM_VARS];
  logic                    vs_impl_q  [NUM_VARS];
  logic [WIDTH_LVL-1:0]    vs_level_q [NUM_VARS];
  logic [WIDTH_BIN_ID-1:0] ls_dcd_q   [NUM_LVLS];
  logic                    ls_bkt_q   [NUM_LVLS];

  // Index range checks; out-of-range writes are dropped and reads return 0.
  logic lit_wr_ok, vs_wr_ok, ls_wr_ok, c_rd_ok, vs_rd_ok, ls_rd_ok;
  assign lit_wr_ok = (32'(lit_cidx_i) < NUM_CLAUSES) && (32'(lit_vidx_i) < NUM_VARS);
  assign vs_wr_ok  = 32'(vs_idx_i) < NUM_VARS;
  assign ls_wr_ok  = 32'(ls_idx_i) < NUM_LVLS;
  assign c_rd_ok   = 32'(c_rd_idx_i) < NUM_CLAUSES;
  assign vs_rd_ok  = 32'(vs_rd_idx_i) < NUM_VARS;
  assign ls_rd_ok  = 32'(ls_rd_idx_i) < NUM_LVLS;

  // Literal matrix: clear, then single-literal write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CLAUSES; c++)
        for (int v = 0; v < NUM_VARS; v++) lit_q[c][v] <= '0;
    end else if (clear_i) begin
      for (int c = 0; c < NUM_CLAUSES; c++)
        for (int v = 0; v < NUM_VARS; v++) lit_q[c][v] <= '0;
    end else if (lit_we_i && lit_wr_ok) begin
      lit_q[lit_cidx_i][lit_vidx_i] <= lit_code_i;
    end
  end

  // Variable states: clear, then bulk unpack (overrides any element write), then element write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VARS; i++) begin
        vs_value_q[i] <= '0;
        vs_impl_q[i]  <= 1'b0;
        vs_level_q[i] <= '0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < NUM_VARS; i++) begin
        vs_value_q[i] <= '0;
        vs_impl_q[i]  <= 1'b0;
        vs_level_q[i] <= '0;
      end
    end else if (vs_load_i) begin
      for (int i = 0; i < NUM_VARS; i++) begin
        vs_value_q[i] <= vars_states_i[WIDTH_VAR_STATES*i+WIDTH_LVL+1 +: 2];
        vs_impl_q[i]  <= vars_states_i[WIDTH_VAR_STATES*i+WIDTH_LVL];
        vs_level_q[i] <= vars_states_i[WIDTH_VAR_STATES*i +: WIDTH_LVL];
      end
    end else if (vs_we_i && vs_wr_ok) begin
      vs_value_q[vs_idx_i] <= vs_value_i;
      vs_impl_q[vs_idx_i]  <= vs_implied_i;
      vs_level_q[vs_idx_i] <= vs_level_i;
    end
  end

  // Level states: same priority order as the variable-state bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LVLS; i++) begin
        ls_dcd_q[i] <= '0;
        ls_bkt_q[i] <= 1'b0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < NUM_LVLS; i++) begin
        ls_dcd_q[i] <= '0;
        ls_bkt_q[i] <= 1'b0;
      end
    end else if (ls_load_i) begin
      for (int i = 0; i < NUM_LVLS; i++) begin
        ls_dcd_q[i] <= lvl_states_i[WIDTH_LVL_STATES*i+1 +: WIDTH_BIN_ID];
        ls_bkt_q[i] <= lvl_states_i[WIDTH_LVL_STATES*i];
      end
    end else if (ls_we_i && ls_wr_ok) begin
      ls_dcd_q[ls_idx_i] <= ls_dcd_bin_i;
      ls_bkt_q[ls_idx_i] <= ls_has_bkt_i;
    end
  end

  // Pack the selected clause row and both state lists into engine bus format.
  always_comb begin
    clause_o      = '0;
    vars_states_o = '0;
    lvl_states_o  = '0;
    if (c_rd_ok) begin
      for (int j = 0; j < NUM_VARS; j++) clause_o[2*j +: 2] = lit_q[c_rd_idx_i][j];
    end
    for (int i = 0; i < NUM_VARS; i++) begin
      vars_states_o[WIDTH_VAR_STATES*i +: WIDTH_VAR_STATES] =
        {vs_value_q[i], vs_impl_q[i], vs_level_q[i]};
    end
    for (int i = 0; i < NUM_LVLS; i++) begin
      lvl_states_o[WIDTH_LVL_STATES*i +: WIDTH_LVL_STATES] = {ls_dcd_q[i], ls_bkt_q[i]};
    end
  end

  // Per-element readback.
  always_comb begin
    vs_value_o   = '0;
    vs_implied_o = 1'b0;
    vs_level_o   = '0;
    ls_dcd_bin_o = '0;
    ls_has_bkt_o = 1'b0;
    if (vs_rd_ok) begin
      vs_value_o   = vs_value_q[vs_rd_idx_i];
      vs_implied_o = vs_impl_q[vs_rd_idx_i];
      vs_level_o   = vs_level_q[vs_rd_idx_i];
    end
    if (ls_rd_ok) begin
      ls_dcd_bin_o = ls_dcd_q[ls_rd_idx_i];
      ls_has_bkt_o = ls_bkt_q[ls_rd_idx_i];
    end
  end

endmodule

// File: tb/tb_clause_array_state_lists.sv
// Directed bench for clause_array_state_lists with hand-computed expected values.
module tb_clause_array_state_lists;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear_i;
  logic         lit_we_i;
  logic [2:0]   lit_cidx_i, lit_vidx_i, c_rd_idx_i;
  logic [1:0]   lit_code_i;
  logic [15:0]  clause_o;
  logic         vs_we_i, vs_implied_i, vs_load_i, vs_implied_o;
  logic [2:0]   vs_idx_i, vs_rd_idx_i;
  logic [1:0]   vs_value_i, vs_value_o;
  logic [15:0]  vs_level_i, vs_level_o;
  logic [151:0] vars_states_i, vars_states_o;
  logic         ls_we_i, ls_has_bkt_i, ls_load_i, ls_has_bkt_o;
  logic [2:0]   ls_idx_i, ls_rd_idx_i;
  logic [9:0]   ls_dcd_bin_i, ls_dcd_bin_o;
  logic [87:0]  lvl_states_i, lvl_states_o;

  int checks = 0;
  int errors = 0;

  logic [151:0] exp_vs, pat_vs;
  logic [87:0]  exp_ls, pat_ls;
  logic [18:0]  vs_tab [4];
  logic [1:0]   val_tab [4];
  logic         imp_tab [4];
  logic [15:0]  lvl_tab [4];

  always #5 clk = ~clk;

  clause_array_state_lists dut (
    .clk(clk), .rst(rst), .clear_i(clear_i),
    .lit_we_i(lit_we_i), .lit_cidx_i(lit_cidx_i), .lit_vidx_i(lit_vidx_i),
    .lit_code_i(lit_code_i), .c_rd_idx_i(c_rd_idx_i), .clause_o(clause_o),
    .vs_we_i(vs_we_i), .vs_idx_i(vs_idx_i), .vs_value_i(vs_value_i),
    .vs_implied_i(vs_implied_i), .vs_level_i(vs_level_i), .vs_load_i(vs_load_i),
    .vars_states_i(vars_states_i), .vars_states_o(vars_states_o),
    .vs_rd_idx_i(vs_rd_idx_i), .vs_value_o(vs_value_o), .vs_implied_o(vs_implied_o),
    .vs_level_o(vs_level_o),
    .ls_we_i(ls_we_i), .ls_idx_i(ls_idx_i), .ls_dcd_bin_i(ls_dcd_bin_i),
    .ls_has_bkt_i(ls_has_bkt_i), .ls_load_i(ls_load_i), .lvl_states_i(lvl_states_i),
    .lvl_states_o(lvl_states_o), .ls_rd_idx_i(ls_rd_idx_i), .ls_dcd_bin_o(ls_dcd_bin_o),
    .ls_has_bkt_o(ls_has_bkt_o)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_lit(input logic [2:0] c, input logic [2:0] v, input logic [1:0] code);
    lit_we_i = 1'b1; lit_cidx_i = c; lit_vidx_i = v; lit_code_i = code;
    tick();
    lit_we_i = 1'b0;
  endtask

  task automatic wr_vs(input logic [2:0] i, input logic [1:0] val, input logic imp,
                       input logic [15:0] lvl);
    vs_we_i = 1'b1; vs_idx_i = i; vs_value_i = val; vs_implied_i = imp; vs_level_i = lvl;
    tick();
    vs_we_i = 1'b0;
  endtask

  task automatic wr_ls(input logic [2:0] i, input logic [9:0] bin, input logic bkt);
    ls_we_i = 1'b1; ls_idx_i = i; ls_dcd_bin_i = bin; ls_has_bkt_i = bkt;
    tick();
    ls_we_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear_i = 1'b0;
    lit_we_i = 1'b0; lit_cidx_i = '0; lit_vidx_i = '0; lit_code_i = '0; c_rd_idx_i = '0;
    vs_we_i = 1'b0; vs_idx_i = '0; vs_value_i = '0; vs_implied_i = 1'b0; vs_level_i = '0;
    vs_load_i = 1'b0; vars_states_i = '0; vs_rd_idx_i = '0;
    ls_we_i = 1'b0; ls_idx_i = '0; ls_dcd_bin_i = '0; ls_has_bkt_i = 1'b0;
    ls_load_i = 1'b0; lvl_states_i = '0; ls_rd_idx_i = '0;
    tick(); tick();
    check("reset_clause", 160'(clause_o), 160'h0);
    check("reset_vs", 160'(vars_states_o), 160'h0);
    check("reset_ls", 160'(lvl_states_o), 160'h0);
    @(negedge clk);
    rst = 1'b0;

    // Clause rows 0 and 2
    wr_lit(3'd0, 3'd0, 2'd2);
    wr_lit(3'd0, 3'd2, 2'd1);
    wr_lit(3'd2, 3'd2, 2'd2);
    wr_lit(3'd2, 3'd4, 2'd2);
    c_rd_idx_i = 3'd0; #1 check("clause_row0", 160'(clause_o), 160'h0012);
    c_rd_idx_i = 3'd2; #1 check("clause_row2", 160'(clause_o), 160'h0220);
    c_rd_idx_i = 3'd1; #1 check("clause_row1", 160'(clause_o), 160'h0000);
    wr_lit(3'd7, 3'd7, 2'd3);
    c_rd_idx_i = 3'd7; #1 check("clause_row7_code3", 160'(clause_o), 160'hC000);

    // Per-variable writes
    val_tab = '{2'd2, 2'd1, 2'd1, 2'd2};
    imp_tab = '{1'b1, 1'b0, 1'b1, 1'b1};
    lvl_tab = '{16'd0, 16'd1, 16'd2, 16'd1};
    vs_tab  = '{19'h50000, 19'h20001, 19'h30002, 19'h50001};
    for (int i = 0; i < 4; i++) wr_vs(3'(i), val_tab[i], imp_tab[i], lvl_tab[i]);
    exp_vs = '0;
    for (int i = 0; i < 4; i++) exp_vs[19*i +: 19] = vs_tab[i];
    check("vs_packed", 160'(vars_states_o), 160'(exp_vs));
    vs_rd_idx_i = 3'd1;
    #1 check("vs_rd1", 160'({vs_value_o, vs_implied_o, vs_level_o}), 160'h20001);

    // Bulk load with a same-cycle element write: the load must win.
    pat_vs = exp_vs;
    pat_vs[19*6 +: 19] = 19'h7ABCD;
    vars_states_i = pat_vs; vs_load_i = 1'b1;
    vs_we_i = 1'b1; vs_idx_i = 3'd5; vs_value_i = 2'd2; vs_implied_i = 1'b1; vs_level_i = 16'd7;
    tick();
    vs_load_i = 1'b0; vs_we_i = 1'b0;
    check("vs_load_wins", 160'(vars_states_o), 160'(pat_vs));
    vs_rd_idx_i = 3'd6;
    #1 check("vs_rd6", 160'({vs_value_o, vs_implied_o, vs_level_o}), 160'h7ABCD);
    vars_states_i = exp_vs; vs_load_i = 1'b1;
    tick();
    vs_load_i = 1'b0;
    check("vs_roundtrip", 160'(vars_states_o), 160'(exp_vs));
    vs_rd_idx_i = 3'd2;
    #1 check("vs_rd2", 160'({vs_value_o, vs_implied_o, vs_level_o}), 160'h30002);

    // Level states
    wr_ls(3'd0, 10'd2, 1'b0);
    check("ls_slice0", 160'(lvl_states_o), 160'h004);
    wr_ls(3'd3, 10'd0, 1'b1);
    exp_ls = '0;
    exp_ls[10:0] = 11'h004;
    exp_ls[33 +: 11] = 11'h001;
    check("ls_slice3", 160'(lvl_states_o), 160'(exp_ls));
    ls_rd_idx_i = 3'd0; #1 check("ls_rd0", 160'({ls_dcd_bin_o, ls_has_bkt_o}), 160'h004);
    ls_rd_idx_i = 3'd3; #1 check("ls_rd3", 160'({ls_dcd_bin_o, ls_has_bkt_o}), 160'h001);
    pat_ls = '0;
    pat_ls[11*5 +: 11] = 11'h5A3;
    pat_ls[11*7 +: 11] = 11'h7FF;
    lvl_states_i = pat_ls; ls_load_i = 1'b1;
    ls_we_i = 1'b1; ls_idx_i = 3'd1; ls_dcd_bin_i = 10'd9; ls_has_bkt_i = 1'b1;
    tick();
    ls_load_i = 1'b0; ls_we_i = 1'b0;
    check("ls_load_wins", 160'(lvl_states_o), 160'(pat_ls));
    ls_rd_idx_i = 3'd5; #1 check("ls_rd5", 160'({ls_dcd_bin_o, ls_has_bkt_o}), 160'h5A3);

    // clear_i: outputs hold until the edge, then everything is zero and the
    // same-cycle literal write is discarded.
    c_rd_idx_i = 3'd0;
    clear_i = 1'b1;
    lit_we_i = 1'b1; lit_cidx_i = 3'd0; lit_vidx_i = 3'd1; lit_code_i = 2'd2;
    #1 check("clear_before_edge", 160'(clause_o), 160'h0012);
    tick();
    clear_i = 1'b0; lit_we_i = 1'b0;
    check("clear_clause", 160'(clause_o), 160'h0);
    check("clear_vs", 160'(vars_states_o), 160'h0);
    check("clear_ls", 160'(lvl_states_o), 160'h0);

    // Asynchronous reset mid-cycle, then writes are ignored while it is held.
    wr_lit(3'd0, 3'd3, 2'd1);
    wr_vs(3'd7, 2'd2, 1'b0, 16'hFFFF);
    wr_ls(3'd2, 10'd1, 1'b1);
    check("pre_rst_clause", 160'(clause_o), 160'h0040);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vs_rd_idx_i = 3'd7; ls_rd_idx_i = 3'd2;
    #1 check("rst_async_clause", 160'(clause_o), 160'h0);
    check("rst_async_vs", 160'(vars_states_o), 160'h0);
    check("rst_async_ls", 160'(lvl_states_o), 160'h0);
    check("rst_async_rd", 160'({vs_value_o, vs_implied_o, vs_level_o, ls_dcd_bin_o,
                                 ls_has_bkt_o}), 160'h0);
    lit_we_i = 1'b1; lit_cidx_i = 3'd0; lit_vidx_i = 3'd0; lit_code_i = 2'd2;
    tick();
    lit_we_i = 1'b0;
    check("rst_blocks_write", 160'(clause_o), 160'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_clause", 160'(clause_o), 160'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clause_array_state_lists.md
# clause_array_state_lists

Parameterised register bank that holds one bin's clause literal matrix, its variable-state list and its level-state list. It packs each into the flat bus formats the SAT engine uses (`clause_i`/`clause_o`, `vars_states_i/o`, `lvl_states_i/o`). It also unpacks engine-format buses back into per-element fields. It sits between the bin loader/checker and `sat_engine`, replacing ad-hoc field packing.

## Interface
- NUM_CLAUSES, 8, clause rows
- NUM_VARS, 8, variables per clause / var-state entries
- NUM_LVLS, 8, level-state entries
- WIDTH_LVL, 16, level field width
- WIDTH_BIN_ID, 10, decided-bin field width
- WIDTH_VAR_STATES, 2+1+WIDTH_LVL (19), var-state slice width
- WIDTH_LVL_STATES, WIDTH_BIN_ID+1 (11), level-state slice width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous clear of all storage
- lit_we_i  in  1  write one literal
- lit_cidx_i  in  clog2(NUM_CLAUSES)  clause index
- lit_vidx_i  in  clog2(NUM_VARS)  variable index
- lit_code_i  in  2  0 absent, 1 negative literal, 2 positive literal
- c_rd_idx_i  in  clog2(NUM_CLAUSES)  clause read select
- clause_o  out  2*NUM_VARS  packed clause
- vs_we_i, vs_idx_i, vs_value_i[1:0], vs_implied_i, vs_level_i[WIDTH_LVL-1:0]  in  per-variable write
- vs_load_i  in  1  bulk load from vars_states_i
- vars_states_i  in  WIDTH_VAR_STATES*NUM_VARS  packed var states
- vars_states_o  out  same  packed var states
- vs_rd_idx_i  in; vs_value_o[1:0], vs_implied_o, vs_level_o  out  per-variable readback
- ls_we_i, ls_idx_i, ls_dcd_bin_i[WIDTH_BIN_ID-1:0], ls_has_bkt_i  in  per-level write
- ls_load_i  in  1  bulk load from lvl_states_i
- lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS  packed level states
- lvl_states_o  out  same  packed level states
- ls_rd_idx_i  in; ls_dcd_bin_o, ls_has_bkt_o  out  per-level readback

## Operation
- Literal code: 2'b10 means the positive literal x (satisfied by var value 2 = true). 2'b01 means ¬x (satisfied by value 1 = false). 2'b00 means absent. 2'b11 is stored unchanged and has no defined meaning.
- Clause packing: var j occupies clause_o[2j+1:2j]. clause_o = row c_rd_idx_i.
- Var-state slice i occupies [WIDTH_VAR_STATES*i +: WIDTH_VAR_STATES], with layout {value[1:0], implied, level[WIDTH_LVL-1:0]}, value in the MSBs.
- Value encoding: 0 unassigned, 1 false, 2 true.
- Level-state slice i occupies [WIDTH_LVL_STATES*i +: WIDTH_LVL_STATES], with layout {dcd_bin[WIDTH_BIN_ID-1:0], has_bkt}, has_bkt in the LSB.
- Write priority per bank, highest first: rst, clear_i (all banks to 0), bulk load, then the per-element write.
- A bulk load and a per-element write in the same cycle: the bulk load wins entirely.
- Bulk loads unpack every slice into its fields. Packed outputs re-pack the stored fields, so a load followed by a read returns identical bits.
- Indices ≥ entry count: writes are ignored, reads return 0.

## Timing
- All storage is flops: written on the rising clk edge and visible the next cycle.
- All outputs are combinational from storage and the read indices; no read latency.
- rst is asserted asynchronously: all storage clears immediately, so clause_o, vars_states_o, lvl_states_o and all readback outputs are 0.
- Writes are ignored while rst is high.
- clear_i takes effect one edge after it is sampled; same-cycle writes are discarded.
- No handshake; every operation is single-cycle, with back-to-back writes every cycle.

## Test plan
- Write row 0 codes {2,0,1,0,0,0,0,0} and row 2 codes {0,0,2,0,2,0,0,0}:
  - c_rd_idx=0 → clause_o=16'h0012.
  - c_rd_idx=2 → 16'h0220.
  - c_rd_idx=1 → 16'h0000.
- Per-variable writes with value {2,1,1,2}, implied {1,0,1,1}, level {0,1,2,1} for vars 0-3:
  - var0 slice=19'h50000, var1=19'h20001, var2=19'h30002, var3=19'h50001.
  - vars 4-7 are 0.
- Bulk-load that vars_states_o value into vars_states_i:
  - vs_rd_idx=2 → value 1, implied 1, level 2.
  - Output is bit-identical to the input.
- ls writes dcd_bin {2,0,...}, has_bkt all 0 → lvl_states_o slice0=11'h004, others 0.
  - Then set has_bkt[3]=1 → slice3=11'h001.
- Asserting clear_i, or rst mid-sequence, zeros every output.
  - For rst this happens immediately; for clear_i it happens at the next edge.
- vs_load_i and vs_we_i in the same cycle → packed input wins.
